// File: rtl/backlyr1_pkg.sv
// Shared constants, state encoding and tap-select helper for the layer-1 backward block.
// Latency: n/a (package).
// Backpressure: n/a (package).
package backlyr1_pkg;

   localparam int DW     = 16;           // Q8.8 data word
   localparam int FRAC   = 8;            // fractional bits
   localparam int N_TAPS = 9;            // taps per neuron in layer 1
   localparam int IDX_W  = 4;            // wide enough for 0..N_TAPS-1
   localparam int FLAT_W = DW * N_TAPS;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TAPS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COMP   = 2'd1,
      STREAM = 2'd2
   } state_t;

   // Pick word idx out of a flattened tap bus (tap i lives at [DW*i +: DW]).
   function automatic logic [DW-1:0] tap_word(input logic [FLAT_W-1:0] flat,
                                              input logic [IDX_W-1:0]  idx);
      return flat[idx*DW +: DW];
   endfunction

endpackage

// File: rtl/backlyr1_mult.sv
// Signed Q8.8 x Q8.8 multiplier returning a Q8.8 result, floor-truncated, wrapping on overflow.
// Latency: combinational.
// Backpressure: none; the caller registers the result.
// Ports: a, b - signed Q8.8 operands; p - product bits [FRAC+DW-1:FRAC].
module backlyr1_mult
   import backlyr1_pkg::*;
(
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] p
);

   logic signed [2*DW-1:0] prod;
   logic                   unused_bits;

   assign prod = $signed(a) * $signed(b);

   // Dropping the low FRAC bits of a two's-complement product rounds toward
   // minus infinity; dropping the high bits gives the wrap-around behaviour.
   assign p = prod[FRAC+DW-1:FRAC];

   assign unused_bits = ^{prod[2*DW-1:FRAC+DW], prod[FRAC-1:0]};

endmodule

// File: rtl/backlyr1.sv
// Layer-1 backward pass: per-tap input error (delta*w) and weight gradient (delta*d), plus bias gradient.
// Latency: first beat 2 cycles after acceptance, then one tap per cycle; 11-cycle sample interval.
// Backpressure: out_ready low freezes the current beat; in_ready only high while IDLE.
// Ports: clk/rst (async active-high); in_valid/in_ready + d_flat/w_flat/delta sample input;
//        out_valid/out_ready + out_idx/out_dx/out_dw/out_db/out_last beat output; busy when not IDLE.
module backlyr1
   import backlyr1_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FLAT_W-1:0] d_flat,
   input  logic [FLAT_W-1:0] w_flat,
   input  logic [DW-1:0]     delta,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_idx,
   output logic [DW-1:0]     out_dx,
   output logic [DW-1:0]     out_dw,
   output logic [DW-1:0]     out_db,
   output logic              out_last,
   output logic              busy
);

   state_t            state;

   // Operands captured at acceptance; input buses are ignored afterwards.
   logic [FLAT_W-1:0] d_q;
   logic [FLAT_W-1:0] w_q;
   logic [DW-1:0]     delta_q;

   logic [IDX_W-1:0]  next_idx;
   logic [IDX_W-1:0]  sel_idx;
   logic [DW-1:0]     w_sel;
   logic [DW-1:0]     d_sel;
   logic [DW-1:0]     dx_res;
   logic [DW-1:0]     dw_res;

   assign next_idx = out_idx + IDX_W'(1);

   // The multipliers always work on the tap that the next register load needs:
   // tap 0 while in COMP, tap out_idx+1 while streaming. On the final tap the
   // select parks at 0 so the index never leaves the operand bus.
   always_comb begin
      sel_idx = '0;
      if (state == STREAM && out_idx != LAST_IDX) begin
         sel_idx = next_idx;
      end
   end

   assign w_sel = tap_word(w_q, sel_idx);
   assign d_sel = tap_word(d_q, sel_idx);

   backlyr1_mult u_mult_dx (
      .a (delta_q),
      .b (w_sel),
      .p (dx_res)
   );

   backlyr1_mult u_mult_dw (
      .a (delta_q),
      .b (d_sel),
      .p (dw_res)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         d_q       <= '0;
         w_q       <= '0;
         delta_q   <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_idx   <= '0;
         out_dx    <= '0;
         out_dw    <= '0;
         out_db    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  d_q     <= d_flat;
                  w_q     <= w_flat;
                  delta_q <= delta;
                  out_idx <= '0;
                  state   <= COMP;
               end
            end

            COMP: begin
               out_dx    <= dx_res;
               out_dw    <= dw_res;
               out_db    <= delta_q;
               out_idx   <= '0;
               out_valid <= 1'b1;
               out_last  <= (N_TAPS == 1);
               state     <= STREAM;
            end

            STREAM: begin
               if (out_ready) begin
                  if (out_idx == LAST_IDX) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     out_dx   <= dx_res;
                     out_dw   <= dw_res;
                     out_idx  <= next_idx;
                     out_last <= (next_idx == LAST_IDX);
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Pure decodes of the state register, so both drop/rise on clock edges only.
   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_backlyr1.sv
module tb_backlyr1;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [143:0] d_flat;
   logic [143:0] w_flat;
   logic [15:0]  delta;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   out_idx;
   logic [15:0]  out_dx;
   logic [15:0]  out_dw;
   logic [15:0]  out_db;
   logic         out_last;
   logic         busy;

   backlyr1 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d_flat    (d_flat),
      .w_flat    (w_flat),
      .delta     (delta),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_dx    (out_dx),
      .out_dw    (out_dw),
      .out_db    (out_db),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: expected beats of the sample under test.
   logic [15:0] ex_dx [9];
   logic [15:0] ex_dw [9];
   logic [15:0] ex_db;

   // Observed beats (one entry per completed handshake).
   logic [3:0]  ob_idx [16];
   logic [15:0] ob_dx  [16];
   logic [15:0] ob_dw  [16];
   logic [15:0] ob_db  [16];
   logic        ob_last[16];
   int          ob_cyc [16];
   int          n_ob;
   int          stall_chg;
   int          stall_cnt;
   int          rdy_viol;
   bit          timeout;

   // Q8.8 product: real value a*b/256 rounded down, kept modulo 2^16.
   function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      if (p < 0) p = -((-p + 255) / 256);
      else       p = p / 256;
      return p[15:0];
   endfunction

   function automatic logic [143:0] rnd_flat();
      logic [143:0] r;
      for (int i = 0; i < 9; i++) r[i*16 +: 16] = 16'($urandom);
      return r;
   endfunction

   task automatic build_model(input logic [143:0] df, input logic [143:0] wf, input logic [15:0] dl);
      for (int i = 0; i < 9; i++) begin
         ex_dx[i] = qmul(dl, wf[i*16 +: 16]);
         ex_dw[i] = qmul(dl, df[i*16 +: 16]);
      end
      ex_db = dl;
   endtask

   // Called #1 after a rising edge. Returns the cycle number in which the
   // sample was accepted, then scrambles the input buses.
   task automatic drive_sample(input logic [143:0] df, input logic [143:0] wf,
                               input logic [15:0] dl, output int acc);
      in_valid = 1'b1;
      d_flat   = df;
      w_flat   = wf;
      delta    = dl;
      acc      = -1;
      for (int k = 0; k < 40; k++) begin
         if (in_ready) begin
            acc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      d_flat   = rnd_flat();
      w_flat   = rnd_flat();
      delta    = 16'($urandom);
      n_cmp++;
      if (acc < 0) begin
         n_bad++;
         $display("FAIL accept_timeout in_ready never seen high within 40 cycles (required high)");
      end
   endtask

   // mode 0: out_ready held high; mode 1: random out_ready.
   // stall_at/stall_len: hold out_ready low for stall_len cycles at that index.
   // abort_at >= 0: return (without a handshake) once that index is on the bus.
   task automatic collect(input int mode, input int stall_at, input int stall_len, input int abort_at);
      logic [3:0]  hidx;
      logic [15:0] hdx;
      logic [15:0] hdw;
      bit          held;
      int          srem;
      held      = 0;
      hidx      = '0;
      hdx       = '0;
      hdw       = '0;
      srem      = stall_len;
      n_ob      = 0;
      stall_chg = 0;
      stall_cnt = 0;
      rdy_viol  = 0;
      timeout   = 1;
      for (int k = 0; k < 200; k++) begin
         if (out_valid && in_ready) rdy_viol++;
         if (held && (out_idx !== hidx || out_dx !== hdx || out_dw !== hdw || out_valid !== 1'b1))
            stall_chg++;
         if (abort_at >= 0 && out_valid && out_idx == 4'(abort_at)) begin
            timeout = 0;
            return;
         end
         if (out_valid && out_idx == 4'(stall_at) && srem > 0) begin
            out_ready = 1'b0;
            srem--;
            stall_cnt++;
            held = 1;
            hidx = out_idx;
            hdx  = out_dx;
            hdw  = out_dw;
         end else begin
            held      = 0;
            out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (out_valid && out_ready && n_ob < 16) begin
            ob_idx[n_ob]  = out_idx;
            ob_dx[n_ob]   = out_dx;
            ob_dw[n_ob]   = out_dw;
            ob_db[n_ob]   = out_db;
            ob_last[n_ob] = out_last;
            ob_cyc[n_ob]  = cyc;
            n_ob++;
            if (out_last) begin
               @(posedge clk); #1;
               timeout = 0;
               return;
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({in_ready, out_valid, out_last, busy} !== 4'b1000) begin
         n_bad++;
         $display("FAIL reset_ctrl got rdy/vld/last/busy=%b required 1000", {in_ready, out_valid, out_last, busy});
      end
      n_cmp++;
      if ({out_idx, out_dx, out_dw, out_db} !== 52'd0) begin
         n_bad++;
         $display("FAIL reset_data got idx=%0d dx=%h dw=%h db=%h required all 0", out_idx, out_dx, out_dw, out_db);
      end
      rst = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      n_cmp++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_bad++;
         $display("FAIL post_reset_idle got rdy/vld/busy=%b required 100", {in_ready, out_valid, busy});
      end
   endtask

   task automatic test_identity();
      logic [143:0] df, wf;
      int acc;
      for (int i = 0; i < 9; i++) begin
         df[i*16 +: 16] = 16'h0080;
         wf[i*16 +: 16] = 16'(i * 256);
      end
      build_model(df, wf, 16'h0100);
      drive_sample(df, wf, 16'h0100, acc);
      collect(0, -1, 0, -1);
      n_cmp++;
      if (timeout || n_ob != 9) begin
         n_bad++;
         $display("FAIL ident_count got %0d beats timeout=%0b required 9", n_ob, timeout);
      end
      for (int i = 0; i < 9; i++) begin
         n_cmp++;
         if ({ob_idx[i], ob_dx[i], ob_dw[i], ob_db[i], ob_last[i], ob_cyc[i]}
             !== {4'(i), 16'(i * 256), 16'h0080, 16'h0100, (i == 8), acc + 2 + i}) begin
            n_bad++;
            $display("FAIL ident_beat%0d got idx=%0d dx=%h dw=%h db=%h last=%b cyc=%0d required idx=%0d dx=%h dw=0080 db=0100 last=%b cyc=%0d",
                     i, ob_idx[i], ob_dx[i], ob_dw[i], ob_db[i], ob_last[i], ob_cyc[i], i, 16'(i * 256), (i == 8), acc + 2 + i);
         end
      end
      n_cmp++;
      if (in_ready !== 1'b1 || rdy_viol != 0) begin
         n_bad++;
         $display("FAIL ident_ready got in_ready=%b busy_ready_cycles=%0d required 1 and 0", in_ready, rdy_viol);
      end
   endtask

   task automatic test_sign_trunc();
      logic [143:0] df, wf;
      int acc;
      df = rnd_flat();
      wf = rnd_flat();
      df[15:0] = 16'h0280;
      build_model(df, wf, 16'hFF00);
      drive_sample(df, wf, 16'hFF00, acc);
      collect(0, -1, 0, -1);
      n_cmp++;
      if (timeout || ob_dw[0] !== 16'hFD80) begin
         n_bad++;
         $display("FAIL sign_dw0 got %h timeout=%0b required fd80", ob_dw[0], timeout);
      end
      for (int i = 0; i < 9; i++) begin
         n_cmp++;
         if ({ob_idx[i], ob_dx[i], ob_dw[i], ob_db[i]} !== {4'(i), ex_dx[i], ex_dw[i], ex_db}) begin
            n_bad++;
            $display("FAIL sign_beat%0d got idx=%0d dx=%h dw=%h db=%h required dx=%h dw=%h db=%h",
                     i, ob_idx[i], ob_dx[i], ob_dw[i], ob_db[i], ex_dx[i], ex_dw[i], ex_db);
         end
      end
      wf = rnd_flat();
      wf[15:0] = 16'h0001;
      drive_sample(rnd_flat(), wf, 16'h0001, acc);
      collect(0, -1, 0, -1);
      n_cmp++;
      if (timeout || ob_dx[0] !== 16'h0000) begin
         n_bad++;
         $display("FAIL trunc_dx0 got %h timeout=%0b required 0000", ob_dx[0], timeout);
      end
   endtask

   task automatic test_overflow();
      logic [143:0] wf;
      int acc;
      wf = rnd_flat();
      wf[3*16 +: 16] = 16'h0200;
      drive_sample(rnd_flat(), wf, 16'h7F00, acc);
      collect(0, -1, 0, -1);
      n_cmp++;
      if (timeout || ob_idx[3] !== 4'd3 || ob_dx[3] !== 16'hFE00) begin
         n_bad++;
         $display("FAIL wrap_dx3 got idx=%0d dx=%h required idx=3 dx=fe00", ob_idx[3], ob_dx[3]);
      end
   endtask

   task automatic test_backpressure();
      logic [143:0] df, wf;
      logic [15:0] dl;
      int acc;
      df = rnd_flat(); wf = rnd_flat(); dl = 16'($urandom);
      build_model(df, wf, dl);
      drive_sample(df, wf, dl, acc);
      collect(0, 4, 3, -1);
      n_cmp++;
      if (stall_cnt != 3 || stall_chg != 0) begin
         n_bad++;
         $display("FAIL bp_hold got stall_cycles=%0d changes=%0d required 3 and 0", stall_cnt, stall_chg);
      end
      n_cmp++;
      if (timeout || n_ob != 9) begin
         n_bad++;
         $display("FAIL bp_count got %0d beats required 9", n_ob);
      end
      for (int i = 0; i < 9; i++) begin
         n_cmp++;
         if ({ob_idx[i], ob_dx[i], ob_dw[i], ob_db[i], ob_last[i]} !== {4'(i), ex_dx[i], ex_dw[i], ex_db, (i == 8)}) begin
            n_bad++;
            $display("FAIL bp_beat%0d got idx=%0d dx=%h dw=%h db=%h last=%b required dx=%h dw=%h db=%h",
                     i, ob_idx[i], ob_dx[i], ob_dw[i], ob_db[i], ob_last[i], ex_dx[i], ex_dw[i], ex_db);
         end
      end
      n_cmp++;
      if (ob_cyc[5] != ob_cyc[4] + 1 || ob_cyc[4] != acc + 2 + 4 + 3) begin
         n_bad++;
         $display("FAIL bp_timing got idx4@%0d idx5@%0d required %0d and %0d", ob_cyc[4], ob_cyc[5], acc + 9, acc + 10);
      end
   endtask

   task automatic test_back_to_back();
      int acc1, acc2;
      drive_sample(rnd_flat(), rnd_flat(), 16'($urandom), acc1);
      collect(0, -1, 0, -1);
      drive_sample(rnd_flat(), rnd_flat(), 16'($urandom), acc2);
      collect(0, -1, 0, -1);
      n_cmp++;
      if (timeout || acc2 - acc1 != 11) begin
         n_bad++;
         $display("FAIL b2b_interval got %0d cycles required 11", acc2 - acc1);
      end
   endtask

   task automatic test_busy_reject();
      logic [143:0] dfa, wfa, dfb, wfb;
      logic [15:0] dla, dlb;
      int acc_a, acc_b, last_a;
      dfa = rnd_flat(); wfa = rnd_flat(); dla = 16'($urandom);
      dfb = rnd_flat(); wfb = rnd_flat(); dlb = 16'($urandom);
      build_model(dfa, wfa, dla);
      drive_sample(dfa, wfa, dla, acc_a);
      in_valid = 1'b1;
      d_flat = dfb; w_flat = wfb; delta = dlb;
      collect(0, -1, 0, -1);
      last_a = ob_cyc[8];
      n_cmp++;
      if (rdy_viol != 0) begin
         n_bad++;
         $display("FAIL busy_ready got in_ready high for %0d streaming cycles required 0", rdy_viol);
      end
      for (int i = 0; i < 9; i++) begin
         n_cmp++;
         if ({ob_idx[i], ob_dx[i], ob_dw[i], ob_db[i]} !== {4'(i), ex_dx[i], ex_dw[i], ex_db}) begin
            n_bad++;
            $display("FAIL busy_a_beat%0d got dx=%h dw=%h db=%h required dx=%h dw=%h db=%h",
                     i, ob_dx[i], ob_dw[i], ob_db[i], ex_dx[i], ex_dw[i], ex_db);
         end
      end
      build_model(dfb, wfb, dlb);
      drive_sample(dfb, wfb, dlb, acc_b);
      n_cmp++;
      if (acc_b != last_a + 1) begin
         n_bad++;
         $display("FAIL busy_accept got cycle %0d required %0d", acc_b, last_a + 1);
      end
      collect(0, -1, 0, -1);
      for (int i = 0; i < 9; i++) begin
         n_cmp++;
         if ({ob_idx[i], ob_dx[i], ob_dw[i], ob_db[i]} !== {4'(i), ex_dx[i], ex_dw[i], ex_db}) begin
            n_bad++;
            $display("FAIL busy_b_beat%0d got dx=%h dw=%h db=%h required dx=%h dw=%h db=%h",
                     i, ob_dx[i], ob_dw[i], ob_db[i], ex_dx[i], ex_dw[i], ex_db);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [143:0] df, wf;
      logic [15:0] dl;
      int acc, stray;
      drive_sample(rnd_flat(), rnd_flat(), 16'($urandom), acc);
      collect(0, -1, 0, 6);
      rst = 1'b1;
      #1;
      n_cmp++;
      if (timeout || {in_ready, out_valid, out_last, busy, out_idx, out_dx, out_dw, out_db} !== {4'b1000, 52'd0}) begin
         n_bad++;
         $display("FAIL rst_mid got rdy=%b vld=%b last=%b busy=%b idx=%0d dx=%h dw=%h db=%h required rdy=1 rest 0",
                  in_ready, out_valid, out_last, busy, out_idx, out_dx, out_dw, out_db);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      stray = 0;
      repeat (4) begin
         if (out_valid) stray++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (stray != 0) begin
         n_bad++;
         $display("FAIL rst_no_beats got %0d valid cycles after abort required 0", stray);
      end
      df = rnd_flat(); wf = rnd_flat(); dl = 16'($urandom);
      build_model(df, wf, dl);
      drive_sample(df, wf, dl, acc);
      collect(0, -1, 0, -1);
      for (int i = 0; i < 9; i++) begin
         n_cmp++;
         if ({ob_idx[i], ob_dx[i], ob_dw[i], ob_db[i], ob_last[i]} !== {4'(i), ex_dx[i], ex_dw[i], ex_db, (i == 8)}) begin
            n_bad++;
            $display("FAIL rst_next_beat%0d got idx=%0d dx=%h dw=%h db=%h required idx=%0d dx=%h dw=%h db=%h",
                     i, ob_idx[i], ob_dx[i], ob_dw[i], ob_db[i], i, ex_dx[i], ex_dw[i], ex_db);
         end
      end
   endtask

   task automatic test_random();
      logic [143:0] df, wf;
      logic [15:0] dl;
      int acc;
      for (int s = 0; s < 6; s++) begin
         df = rnd_flat(); wf = rnd_flat(); dl = 16'($urandom);
         build_model(df, wf, dl);
         drive_sample(df, wf, dl, acc);
         collect(1, -1, 0, -1);
         n_cmp++;
         if (timeout || n_ob != 9) begin
            n_bad++;
            $display("FAIL rand%0d_count got %0d beats timeout=%0b required 9", s, n_ob, timeout);
         end
         for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if ({ob_idx[i], ob_dx[i], ob_dw[i], ob_db[i], ob_last[i]} !== {4'(i), ex_dx[i], ex_dw[i], ex_db, (i == 8)}) begin
               n_bad++;
               $display("FAIL rand%0d_beat%0d got idx=%0d dx=%h dw=%h db=%h last=%b required dx=%h dw=%h db=%h",
                        s, i, ob_idx[i], ob_dx[i], ob_dw[i], ob_db[i], ob_last[i], ex_dx[i], ex_dw[i], ex_db);
            end
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      d_flat    = '0;
      w_flat    = '0;
      delta     = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_identity();
      test_sign_trunc();
      test_overflow();
      test_backpressure();
      test_back_to_back();
      test_busy_reject();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/backlyr1.md
Name: backlyr1

Overview:
- Backward-pass companion to the layer-1 9-tap forward MAC.
- Accepts one sample's saved 9 activations, 9 weights and the upstream error delta.
- Streams per-tap input-error and weight-gradient results, plus the bias gradient.
- Two shared fixed-point multiplier instances are time-multiplexed over the taps, one tap per beat; feeds the weight-update and previous-layer backprop logic.

Parameters:
- N_TAPS, 9, number of taps per neuron (fixed at 9 for layer 1).
- DW, 16, data word width, signed Q8.8.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  sample operands valid
- in_ready  out  1  block can accept a sample
- d_flat  in  DW*N_TAPS  activations; tap i at [16i+15:16i]
- w_flat  in  DW*N_TAPS  weights; tap i at [16i+15:16i]
- delta  in  DW  upstream error for this neuron
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_idx  out  4  tap index of current beat, 0..8
- out_dx  out  DW  delta*w[idx], error propagated to input idx
- out_dw  out  DW  delta*d[idx], weight gradient for tap idx
- out_db  out  DW  bias gradient (= latched delta)
- out_last  out  1  high on beat idx==8
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any time, including mid-stream):
  - state=IDLE, in_ready=1, out_valid=0, out_last=0, busy=0.
  - out_idx, out_dx, out_dw, out_db and all operand registers = 0.
  - An aborted sample emits no further beats.
- Arithmetic (one mult instance per product):
  - Signed 16x16 to 32-bit product; result = product[23:8].
  - Truncation toward minus infinity, no saturation; overflow wraps in 16 bits.
- States: IDLE, COMP, STREAM.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch d_flat, w_flat, delta; idx=0; go to COMP.
- COMP (1 cycle, in_ready=0):
  - Load out_dx/out_dw/out_db/out_idx from tap 0; out_valid=1; out_last=(N_TAPS==1); go to STREAM.
- STREAM:
  - Output registers hold steady while out_valid&&!out_ready.
  - On handshake with idx<8: same edge loads tap idx+1 results, out_idx=idx+1, out_last=(idx+1==8), out_valid stays 1.
  - On handshake with idx==8: out_valid=0, out_last=0, return to IDLE.
  - in_ready=1 is reasserted the cycle after the last handshake.
- Timing:
  - First beat valid 2 cycles after acceptance.
  - Full throughput 1 beat/cycle with out_ready held high; sample-to-sample interval 11 cycles.
  - No sample overlap: in_ready=0 outside IDLE; in_valid in COMP/STREAM is ignored.
- Operand registers are unaffected by input bus changes after acceptance.
- out_db equals the latched delta on every beat.

Decomposition:
- Shared package: DW=16, FRAC=8, N_TAPS=9, IDX_W=4, state encoding (IDLE/COMP/STREAM).
- Sub-module: existing mult, two instances (dx path, dw path) fed by idx-muxed operand registers.
- No other sub-modules.

Test Plan:
- Identity: delta=0x0100, w_i=i*0x0100, d_i=0x0080, out_ready=1
  -> 9 consecutive beats starting 2 cycles after accept; out_dx=i*0x0100, out_dw=0x0080, out_db=0x0100; out_last only on idx 8.
- Sign/rounding: delta=0xFF00, d_0=0x0280 -> out_dw[0]=0xFD80. Separately, delta=0x0001, w_0=0x0001 -> out_dx[0]=0x0000 (truncated).
- Overflow wrap: delta=0x7F00, w_3=0x0200 -> out_dx at idx 3 = 0xFE00, no saturation.
- Backpressure: out_ready low for 3 cycles at idx 4
  -> out_idx/out_dx/out_dw stable, out_valid held 1; stream resumes at idx 5 with no beat lost or repeated.
- Busy rejection: in_valid held high with new operands during STREAM
  -> in_ready=0 and no corruption; the second sample is accepted only the cycle after the idx-8 handshake, and its results use its own values.
- Reset mid-stream: assert rst at idx 6
  -> all outputs 0 and in_ready=1 immediately; the next sample streams from idx 0 correctly.
